axis_frame_arbiter: RTL and testbench
=====================================

# axis_frame_arbiter

Frame-level arbiter and sequencer for the N-to-1 AXI-Stream switch datapath: S_COUNT sources request the shared output, and the block issues one registered one-hot grant at a time. The grant is held until the granted frame's last beat is accepted at the switch output, and the datapath mux selects on `grant_encoded`. Round-robin or fixed-priority selection is chosen by parameter. An optional watchdog frees the output if the granted source stalls mid-frame.

## Interface
- S_COUNT, 4: number of requesting sources (2..16)
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority
- ARB_LSB_HIGH_PRIORITY, 1: 1 = index 0 wins ties/fixed priority, 0 = index S_COUNT-1 wins
- TIMEOUT_CYCLES, 256: watchdog limit in cycles (>=2; only used when the macro is defined)
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- request  input  S_COUNT  per-source request; normally s_axis_tvalid
- beat_valid  input  1  tvalid at switch output
- beat_ready  input  1  tready at switch output
- beat_last  input  1  tlast at switch output
- grant  output  S_COUNT  registered one-hot grant
- grant_valid  output  1  OR of grant
- grant_encoded  output  $clog2(S_COUNT)  binary index of grant; 0 when no grant
- timeout  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE (no grant), LOCKED (one grant held).
- Accepted beat: beat_valid && beat_ready. Frame end: accepted beat && beat_last.
- IDLE: if request != 0, select a winner, load grant, go LOCKED next cycle. Otherwise stay in IDLE.
- LOCKED: grant stays fixed regardless of request changes, including when the granted source drops its request.
- LOCKED and frame end: re-arbitrate in the same cycle on the current request vector.
  - If there is a winner, the next cycle holds the new grant (zero-bubble, back-to-back frames).
  - If there is none, go IDLE with grant=0.
- Round-robin: a mask keeps only indices strictly after the last granted index in priority order.
  - The masked vector is tried first; the unmasked vector is the fallback.
  - The last-granted index updates only when a new grant loads.
- Fixed priority: the highest-priority asserted request wins every arbitration.
- A source that is still requesting when its frame ends is re-granted only if no other source requests (round-robin mode).
- A single-beat frame (last on the first beat) releases after exactly one accepted beat.

## Timing
- Reset values: grant=0, grant_valid=0, grant_encoded=0, timeout=0, state IDLE, last-granted index = S_COUNT-1 (so index 0 is first in the LSB-high round-robin order), watchdog count=0.
- Request-to-grant latency: 1 cycle from IDLE.
- Frame end at cycle t: the new grant is visible at t+1, and the old grant is never visible at t+1.
- grant, grant_valid, grant_encoded and timeout are all registered; there is no combinational path from inputs to outputs.
- Asserting rst mid-frame clears everything on the next edge. The datapath must discard the partial frame.

## Configuration
- Macro AXIS_FRAME_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in LOCKED, clears on every accepted beat and on each new grant, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no accepted beat that cycle, it forces a release identical to frame end (same-cycle re-arbitration).
  - timeout pulses high for one cycle, coincident with the new grant.
- Undefined: no counter is built, timeout is tied to 0, and a stalled source holds the grant indefinitely.

## Structure
- Shared package axis_arb_pkg:
  - ARB_STATE_IDLE and ARB_STATE_LOCKED encodings.
  - Function clog2_min1, returning width 1 when S_COUNT=1.
- Sub-module priority_encoder (WIDTH, LSB_HIGH_PRIORITY): outputs valid, encoded index and one-hot.
  - Instantiated twice, for the masked and unmasked request vectors.

## Test plan
- Reset, then request=4'b0101 → grant=4'b0001 one cycle later. Frame end of 3 beats → grant=4'b0100 at the next cycle, no bubble.
- Round-robin: request=4'b1111 held, 1-beat frames each accepted → grant sequence 0001, 0010, 0100, 1000, 0001.
- Fixed priority (ARB_TYPE_ROUND_ROBIN=0): request=4'b1111, repeated frames → grant always 4'b0001. With ARB_LSB_HIGH_PRIORITY=0 → always 4'b1000.
- Granted source drops request mid-frame with beat_ready=0 → grant held. request=0 at frame end → grant=0, grant_valid=0 next cycle.
- Macro defined, TIMEOUT_CYCLES=8: grant source 1, no accepted beats, request=4'b0110 → timeout pulses 8 cycles after grant, with grant=4'b0100 in the same cycle. Macro undefined → grant stays 4'b0010 for 100 cycles and timeout stays 0.
- rst asserted mid-frame while grant=4'b0010 → grant=0 next edge. After release with request=4'b1111 → grant=4'b0001 (round-robin pointer reset).

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream frame arbiter: FSM state encodings
// and a width helper that never returns zero.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_STATE_IDLE   = 1'b0,
        ARB_STATE_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n items; a single item still needs a 1-bit field.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: reports whether any input bit is set, the index of the
// highest-priority set bit, and that bit as a one-hot vector.
module priority_encoder
    import axis_arb_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 1
) (
    input  logic [WIDTH-1:0]                  input_unencoded,
    output logic                              output_valid,
    output logic [clog2_min1(WIDTH)-1:0]      output_encoded,
    output logic [WIDTH-1:0]                  output_unencoded
);

    localparam int EW = clog2_min1(WIDTH);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        output_valid     = |input_unencoded;
        output_encoded   = '0;
        output_unencoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) begin
                    output_encoded      = EW'(i);
                    output_unencoded    = '0;
                    output_unencoded[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) begin
                    output_encoded      = EW'(i);
                    output_unencoded    = '0;
                    output_unencoded[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level arbiter for an N-to-1 AXI-Stream switch. Holds one registered
// one-hot grant until the granted frame's last beat is accepted, then
// re-arbitrates in the same cycle so back-to-back frames have no bubble.
// Optional stall watchdog enabled by defining AXIS_FRAME_ARB_TIMEOUT_EN.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT               = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter int ARB_LSB_HIGH_PRIORITY = 1,
    parameter int TIMEOUT_CYCLES        = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [S_COUNT-1:0]               request,
    input  logic                             beat_valid,
    input  logic                             beat_ready,
    input  logic                             beat_last,
    output logic [S_COUNT-1:0]               grant,
    output logic                             grant_valid,
    output logic [clog2_min1(S_COUNT)-1:0]   grant_encoded,
    output logic                             timeout
);

    localparam int CL = clog2_min1(S_COUNT);

    arb_state_t          r_state;
    logic [S_COUNT-1:0]  r_grant;
    logic                r_grant_valid;
    logic [CL-1:0]       r_grant_enc;
    logic [CL-1:0]       r_last;

    logic [S_COUNT-1:0]  w_mask;
    logic [S_COUNT-1:0]  w_masked_req;
    logic                w_m_valid, w_u_valid, w_sel_valid;
    logic [CL-1:0]       w_m_enc, w_u_enc, w_sel_enc;
    logic [S_COUNT-1:0]  w_m_onehot, w_u_onehot, w_sel_onehot;
    logic                w_accept, w_frame_end, w_tmo_fire, w_arb;

    assign w_accept    = beat_valid && beat_ready;
    assign w_frame_end = (r_state == ARB_STATE_LOCKED) && w_accept && beat_last;
    assign w_arb       = (r_state == ARB_STATE_IDLE) || w_frame_end || w_tmo_fire;

    // Keep only sources strictly after the last granted one in priority order.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (ARB_LSB_HIGH_PRIORITY != 0)
                w_mask[i] = (i > int'(r_last));
            else
                w_mask[i] = (i < int'(r_last));
        end
    end

    assign w_masked_req = request & w_mask;

    priority_encoder #(
        .WIDTH             (S_COUNT),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .input_unencoded  (w_masked_req),
        .output_valid     (w_m_valid),
        .output_encoded   (w_m_enc),
        .output_unencoded (w_m_onehot)
    );

    priority_encoder #(
        .WIDTH             (S_COUNT),
        .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_enc_full (
        .input_unencoded  (request),
        .output_valid     (w_u_valid),
        .output_encoded   (w_u_enc),
        .output_unencoded (w_u_onehot)
    );

    // Round-robin prefers the masked winner and wraps to the full vector.
    always_comb begin
        w_sel_valid  = w_u_valid;
        w_sel_enc    = w_u_enc;
        w_sel_onehot = w_u_onehot;
        if ((ARB_TYPE_ROUND_ROBIN != 0) && w_m_valid) begin
            w_sel_valid  = 1'b1;
            w_sel_enc    = w_m_enc;
            w_sel_onehot = w_m_onehot;
        end
    end

    // Grant FSM: load a winner when idle or on release, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB_STATE_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_enc   <= '0;
            r_last        <= CL'(S_COUNT - 1);
        end else if (w_arb) begin
            if (w_sel_valid) begin
                r_state       <= ARB_STATE_LOCKED;
                r_grant       <= w_sel_onehot;
                r_grant_valid <= 1'b1;
                r_grant_enc   <= w_sel_enc;
                r_last        <= w_sel_enc;
            end else begin
                r_state       <= ARB_STATE_IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_enc   <= '0;
            end
        end
    end

`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
    localparam int WDW = clog2_min1(TIMEOUT_CYCLES);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_timeout;

    assign w_tmo_fire = (r_state == ARB_STATE_LOCKED) && !w_accept &&
                        (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    // Stall watchdog: counts idle cycles of a held grant, forces a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_fire;
            if (w_arb || w_accept)
                r_wd_cnt <= '0;
            else if (r_state == ARB_STATE_LOCKED)
                r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_tmo_fire = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_enc;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: a round-robin instance plus two
// fixed-priority instances (LSB-high and MSB-high) share one stimulus.
module tb_axis_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request;
    logic       beat_valid, beat_ready, beat_last;

    logic [3:0] grant,    grant_fp,    grant_fm;
    logic       gvalid,   gvalid_fp,   gvalid_fm;
    logic [1:0] genc,     genc_fp,     genc_fm;
    logic       tmo,      tmo_fp,      tmo_fm;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .S_COUNT(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .request(request), .beat_valid(beat_valid),
        .beat_ready(beat_ready), .beat_last(beat_last), .grant(grant),
        .grant_valid(gvalid), .grant_encoded(genc), .timeout(tmo)
    );

    axis_frame_arbiter #(
        .S_COUNT(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT_CYCLES(256)
    ) dut_fp (
        .clk(clk), .rst(rst), .request(request), .beat_valid(beat_valid),
        .beat_ready(beat_ready), .beat_last(beat_last), .grant(grant_fp),
        .grant_valid(gvalid_fp), .grant_encoded(genc_fp), .timeout(tmo_fp)
    );

    axis_frame_arbiter #(
        .S_COUNT(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(0), .TIMEOUT_CYCLES(256)
    ) dut_fm (
        .clk(clk), .rst(rst), .request(request), .beat_valid(beat_valid),
        .beat_ready(beat_ready), .beat_last(beat_last), .grant(grant_fm),
        .grant_valid(gvalid_fm), .grant_encoded(genc_fm), .timeout(tmo_fm)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic r, input logic l);
        beat_valid = v;
        beat_ready = r;
        beat_last  = l;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        request = 4'b0000;
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant: got %b want 0000", grant);
        end
        n_checks++;
        if (gvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_grant_valid: got %b want 0", gvalid);
        end
        n_checks++;
        if (genc !== 2'd0) begin
            n_errors++; $display("FAIL reset_grant_encoded: got %0d want 0", genc);
        end
        n_checks++;
        if (tmo !== 1'b0) begin
            n_errors++; $display("FAIL reset_timeout: got %b want 0", tmo);
        end
        step();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++; $display("FAIL idle_no_request: got %b want 0000", grant);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        request = 4'b0101;
        step();
        n_checks++;
        if (grant !== 4'b0001 || genc !== 2'd0 || gvalid !== 1'b1) begin
            n_errors++; $display("FAIL first_grant: got %b/%0d/%b want 0001/0/1", grant, genc, gvalid);
        end
        set_beat(1'b1, 1'b1, 1'b0);
        step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_errors++; $display("FAIL hold_mid_frame: got %b want 0001", grant);
        end
        step();
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        n_checks++;
        if (grant !== 4'b0100 || genc !== 2'd2 || gvalid !== 1'b1) begin
            n_errors++; $display("FAIL zero_bubble: got %b/%0d/%b want 0100/2/1", grant, genc, gvalid);
        end
        request = 4'b0000;
        step();
        n_checks++;
        if (grant !== 4'b0000 || gvalid !== 1'b0 || genc !== 2'd0) begin
            n_errors++; $display("FAIL release_to_idle: got %b/%b/%0d want 0000/0/0", grant, gvalid, genc);
        end
        set_beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin_and_fixed();
        logic [3:0] exp_rr [5];
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        do_reset();
        request = 4'b1111;
        set_beat(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (grant !== exp_rr[i]) begin
                n_errors++; $display("FAIL rr_seq[%0d]: got %b want %b", i, grant, exp_rr[i]);
            end
            n_checks++;
            if (grant_fp !== 4'b0001) begin
                n_errors++; $display("FAIL fixed_lsb[%0d]: got %b want 0001", i, grant_fp);
            end
            n_checks++;
            if (grant_fm !== 4'b1000 || genc_fm !== 2'd3) begin
                n_errors++; $display("FAIL fixed_msb[%0d]: got %b/%0d want 1000/3", i, grant_fm, genc_fm);
            end
        end
        request = 4'b0000;
        step();
        set_beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hold_on_drop();
        do_reset();
        request = 4'b0010;
        step();
        n_checks++;
        if (grant !== 4'b0010 || genc !== 2'd1) begin
            n_errors++; $display("FAIL hold_initial: got %b/%0d want 0010/1", grant, genc);
        end
        request = 4'b0000;
        set_beat(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (grant !== 4'b0010 || gvalid !== 1'b1) begin
                n_errors++; $display("FAIL hold_dropped[%0d]: got %b/%b want 0010/1", i, grant, gvalid);
            end
        end
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        n_checks++;
        if (grant !== 4'b0000 || gvalid !== 1'b0) begin
            n_errors++; $display("FAIL hold_release_idle: got %b/%b want 0000/0", grant, gvalid);
        end
        set_beat(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog();
        do_reset();
        request = 4'b0010;
        step();
        request = 4'b0110;
        set_beat(1'b0, 1'b0, 1'b0);
`ifdef AXIS_FRAME_ARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            n_checks++;
            if (tmo !== 1'b0 || grant !== 4'b0010) begin
                n_errors++; $display("FAIL wd_before[%0d]: got tmo=%b grant=%b want 0/0010", i, tmo, grant);
            end
        end
        step();
        n_checks++;
        if (tmo !== 1'b1 || grant !== 4'b0100) begin
            n_errors++; $display("FAIL wd_fire: got tmo=%b grant=%b want 1/0100", tmo, grant);
        end
        step();
        n_checks++;
        if (tmo !== 1'b0 || grant !== 4'b0100) begin
            n_errors++; $display("FAIL wd_pulse_end: got tmo=%b grant=%b want 0/0100", tmo, grant);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            n_checks++;
            if (tmo !== 1'b0 || grant !== 4'b0010) begin
                n_errors++; $display("FAIL no_wd[%0d]: got tmo=%b grant=%b want 0/0010", i, tmo, grant);
            end
        end
`endif
        request = 4'b0000;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        request = 4'b1111;
        step();
        set_beat(1'b1, 1'b1, 1'b1);
        step();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_errors++; $display("FAIL mid_setup: got %b want 0010", grant);
        end
        set_beat(1'b1, 1'b1, 1'b0);
        step();
        n_checks++;
        if (grant !== 4'b0010) begin
            n_errors++; $display("FAIL mid_hold: got %b want 0010", grant);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (grant !== 4'b0000 || gvalid !== 1'b0 || genc !== 2'd0) begin
            n_errors++; $display("FAIL mid_reset_clear: got %b/%b/%0d want 0000/0/0", grant, gvalid, genc);
        end
        rst = 1'b0;
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_errors++; $display("FAIL rr_pointer_reset: got %b want 0001", grant);
        end
        request = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_round_robin_and_fixed();
        test_hold_on_drop();
        test_watchdog();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
